// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-controller bus: control inputs, instruction-memory port and IF/ID outputs.
// FETCH_PERF_CNT_EN adds the cycle/stall/flush counter outputs.
interface instr_fetch_ctrl_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
);
    logic               start;
    logic               stall;
    logic               branch;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic               done;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        cycle_cnt;
    logic [31:0]        stall_cnt;
    logic [15:0]        flush_cnt;
`endif

    modport master (
        input  start, stall, branch, branch_target, imem_rdata,
        output imem_addr, instr_out, instr_pc, instr_valid, pc, done
`ifdef FETCH_PERF_CNT_EN
        , output cycle_cnt, stall_cnt, flush_cnt
`endif
    );

    modport slave (
        output start, stall, branch, branch_target, imem_rdata,
        input  imem_addr, instr_out, instr_pc, instr_valid, pc, done
`ifdef FETCH_PERF_CNT_EN
        , input cycle_cnt, stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: IDLE/RUN/DRAIN/DONE sequencer over a combinational ROM.
// Optional FETCH_PERF_CNT_EN adds saturating cycle/stall/flush counters.
module instr_fetch_ctrl #(
    parameter int                  PC_W         = 10,
    parameter int                  INSTR_W      = 9,
    parameter logic [INSTR_W-1:0]  HALT_INSTR   = '1,
    parameter int                  DRAIN_CYCLES = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    instr_fetch_ctrl_if.master  bus
);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    ipc_q, ipc_d;
    logic               vld_q, vld_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_acc;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        vld_d     = vld_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d  = '0;
                vld_d = 1'b0;
                // The start edge only arms RUN; the first fetch happens one edge later.
                if (bus.start) begin
                    state_d   = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                if (bus.branch) begin
                    pc_d  = bus.branch_target;
                    vld_d = 1'b0;
                end else if (!bus.stall) begin
                    instr_d = bus.imem_rdata;
                    ipc_d   = pc_q;
                    vld_d   = 1'b1;
                    if (bus.imem_rdata == HALT_INSTR) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(DRAIN_CYCLES);
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // A late branch means the halt was fetched down a wrong path.
                if (bus.branch) begin
                    pc_d    = bus.branch_target;
                    vld_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (!bus.stall) begin
                    vld_d = 1'b0;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                vld_d = 1'b0;
                if (bus.start) begin
                    pc_d      = '0;
                    done_d    = 1'b0;
                    state_d   = RUN;
                    start_acc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_valid = vld_q;
    assign bus.done        = done_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cyc_q, stl_q;
    logic [15:0] fls_q;
    logic        active;

    assign active = (state_q == RUN) || (state_q == DRAIN);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cyc_q <= '0;
            stl_q <= '0;
            fls_q <= '0;
        end else if (start_acc) begin
            cyc_q <= '0;
            stl_q <= '0;
            fls_q <= '0;
        end else if (active) begin
            if (cyc_q != '1)
                cyc_q <= cyc_q + 32'd1;
            if ((state_q == RUN) && bus.stall && !bus.branch && (stl_q != '1))
                stl_q <= stl_q + 32'd1;
            if (bus.branch && (fls_q != '1))
                fls_q <= fls_q + 16'd1;
        end
    end

    assign bus.cycle_cnt = cyc_q;
    assign bus.stall_cnt = stl_q;
    assign bus.flush_cnt = fls_q;
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_instr_fetch_ctrl;
    localparam int         PC_W    = 10;
    localparam int         INSTR_W = 9;
    localparam int         DRAIN   = 4;
    localparam logic [8:0] HALT    = 9'h1FF;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] rom [0:1023];
    int         n_chk  = 0;
    int         n_fail = 0;

    instr_fetch_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    instr_fetch_ctrl #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .HALT_INSTR(HALT), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    assign bus.imem_rdata = rom[bus.imem_addr];

    always #5 clk = ~clk;

    typedef struct {
        logic       st, stl, br;
        logic [9:0] tg;
        logic [9:0] e_pc, e_ipc;
        logic [8:0] e_ins;
        logic       e_vld, e_done;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(logic st, logic stl, logic br, logic [9:0] tg,
                                logic [9:0] e_pc, logic [9:0] e_ipc, logic [8:0] e_ins,
                                logic e_vld, logic e_done);
        vec_t v;
        v.st = st; v.stl = stl; v.br = br; v.tg = tg;
        v.e_pc = e_pc; v.e_ipc = e_ipc; v.e_ins = e_ins; v.e_vld = e_vld; v.e_done = e_done;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic st, input logic br, input logic [9:0] tg);
        bus.start = s; bus.stall = st; bus.branch = br; bus.branch_target = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic rom_default();
        for (int a = 0; a < 1024; a++) rom[a] = 9'((a * 7 + 3) & 8'hFF);
        for (int a = 0; a < 5; a++) rom[a] = 9'(a + 1);
        rom[5] = HALT;
    endtask

    task automatic chk_out(input string nm, input logic [9:0] pc, input logic [9:0] ipc,
                           input logic vld, input logic dn);
        chk({nm, ".pc"},    bus.pc, pc);
        chk({nm, ".ipc"},   bus.instr_pc, ipc);
        chk({nm, ".valid"}, bus.instr_valid, vld);
        chk({nm, ".done"},  bus.done, dn);
    endtask

    // behavioural model state
    logic        m_act, m_fin;
    int          m_drain;
    logic [9:0]  m_pc, m_ipc;
    logic [8:0]  m_ins;
    logic        m_vld;
    int          m_cyc, m_sc, m_fl;

    task automatic model_reset();
        m_act = 0; m_fin = 0; m_drain = 0; m_pc = '0; m_ipc = '0; m_ins = '0; m_vld = 0;
        m_cyc = 0; m_sc = 0; m_fl = 0;
    endtask

    task automatic model_edge(input logic s, input logic st, input logic br, input logic [9:0] tg);
        if (!m_act && !m_fin) begin
            if (s) begin m_act = 1; m_cyc = 0; m_sc = 0; m_fl = 0; end
        end else if (m_fin) begin
            if (s) begin m_fin = 0; m_act = 1; m_pc = '0; m_cyc = 0; m_sc = 0; m_fl = 0; end
        end else begin
            m_cyc++;
            if (br) m_fl++;
            else if (st && m_drain == 0) m_sc++;
            if (br) begin
                m_pc = tg; m_vld = 0; m_drain = 0;
            end else if (!st) begin
                if (m_drain > 0) begin
                    m_vld = 0;
                    m_drain--;
                    if (m_drain == 0) begin m_fin = 1; m_act = 0; end
                end else begin
                    m_ins = rom[m_pc]; m_ipc = m_pc; m_vld = 1;
                    if (rom[m_pc] == HALT) m_drain = DRAIN;
                    else m_pc = m_pc + 10'd1;
                end
            end
        end
    endtask

    initial begin
        bus.start = 0; bus.stall = 0; bus.branch = 0; bus.branch_target = '0;
        rom_default();
        #3;
        chk_out("reset", 10'h0, 10'h0, 1'b0, 1'b0);
        chk("reset.instr", bus.instr_out, 9'h0);
        @(negedge clk);
        reset = 1'b0;

        // full program run, drain, done, restart
        tbl[0]  = mk(0, 0, 0, 10'h0,   10'h0, 10'h0, 9'h000, 0, 0);
        tbl[1]  = mk(1, 0, 0, 10'h0,   10'h0, 10'h0, 9'h000, 0, 0);
        tbl[2]  = mk(0, 0, 0, 10'h0,   10'h1, 10'h0, 9'h001, 1, 0);
        tbl[3]  = mk(0, 0, 0, 10'h0,   10'h2, 10'h1, 9'h002, 1, 0);
        tbl[4]  = mk(0, 0, 0, 10'h0,   10'h3, 10'h2, 9'h003, 1, 0);
        tbl[5]  = mk(0, 0, 0, 10'h0,   10'h4, 10'h3, 9'h004, 1, 0);
        tbl[6]  = mk(0, 0, 0, 10'h0,   10'h5, 10'h4, 9'h005, 1, 0);
        tbl[7]  = mk(0, 0, 0, 10'h0,   10'h5, 10'h5, HALT,   1, 0);
        tbl[8]  = mk(1, 0, 0, 10'h0,   10'h5, 10'h5, HALT,   0, 0);
        tbl[9]  = mk(0, 0, 0, 10'h0,   10'h5, 10'h5, HALT,   0, 0);
        tbl[10] = mk(0, 0, 0, 10'h0,   10'h5, 10'h5, HALT,   0, 0);
        tbl[11] = mk(0, 0, 0, 10'h0,   10'h5, 10'h5, HALT,   0, 1);
        tbl[12] = mk(0, 1, 1, 10'h055, 10'h5, 10'h5, HALT,   0, 1);
        tbl[13] = mk(1, 0, 0, 10'h0,   10'h0, 10'h5, HALT,   0, 0);
        tbl[14] = mk(0, 0, 0, 10'h0,   10'h1, 10'h0, 9'h001, 1, 0);
        #1;
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].st, tbl[i].stl, tbl[i].br, tbl[i].tg);
            chk_out($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_ipc, tbl[i].e_vld, tbl[i].e_done);
            chk($sformatf("vec%0d.instr", i), bus.instr_out, tbl[i].e_ins);
            chk($sformatf("vec%0d.addr", i), bus.imem_addr, tbl[i].e_pc);
        end

        // stall held three cycles at pc=3
        pulse_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk_out("stall.pre", 10'h3, 10'h2, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk_out($sformatf("stall.hold%0d", i), 10'h3, 10'h2, 1, 0);
        end
        step(0, 0, 0, 0);
        chk_out("stall.release", 10'h4, 10'h3, 1, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("stall.stall_cnt", bus.stall_cnt, 32'd3);
`endif

        // branch beats stall
        step(0, 1, 1, 10'h020);
        chk_out("brstall.redirect", 10'h020, 10'h3, 0, 0);
        step(0, 0, 0, 0);
        chk_out("brstall.fetch", 10'h021, 10'h020, 1, 0);
        chk("brstall.instr", bus.instr_out, rom[10'h020]);

        // branch in second drain cycle rescues the wrong-path halt
        pulse_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        chk_out("drain.halt", 10'h5, 10'h5, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 10'h010);
        chk_out("drain.branch", 10'h010, 10'h5, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk_out("drain.resume", 10'h015, 10'h014, 1, 0);

        // asynchronous reset mid-run, then idle until start
        pulse_reset();
        step(1, 0, 0, 0);
        step(0, 0, 1, 10'h006);
        step(0, 0, 0, 0);
        chk_out("areset.pre", 10'h007, 10'h006, 1, 0);
        #2 reset = 1'b1;
        #1;
        chk_out("areset.now", 10'h0, 10'h0, 0, 0);
        reset = 1'b0;
        #1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_out("areset.idle", 10'h0, 10'h0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_out("areset.resume", 10'h1, 10'h0, 1, 0);

        // PC wrap from all-ones
        step(0, 0, 1, 10'h3FF);
        chk("wrap.pc0", bus.pc, 10'h3FF);
        step(0, 0, 0, 0);
        chk_out("wrap.pc1", 10'h000, 10'h3FF, 1, 0);
        step(0, 0, 0, 0);
        chk_out("wrap.pc2", 10'h001, 10'h000, 1, 0);

        // randomized traffic against the model
        for (int a = 0; a < 1024; a++)
            rom[a] = ($urandom_range(0, 15) == 0) ? HALT : 9'($urandom & 32'hFF);
        pulse_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic s, st, br;
            logic [9:0] tg;
            s  = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 9) == 0);
            tg = 10'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
                model_reset();
            end
            model_edge(s, st, br, tg);
            step(s, st, br, tg);
            chk_out($sformatf("rand%0d", c), m_pc, m_ipc, m_vld, m_fin);
            chk($sformatf("rand%0d.instr", c), bus.instr_out, m_ins);
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("rand%0d.cyc", c), bus.cycle_cnt, m_cyc);
            chk($sformatf("rand%0d.stl", c), bus.stall_cnt, m_sc);
            chk($sformatf("rand%0d.fls", c), bus.flush_cnt, m_fl);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
